// File: rtl/led_seq_pkg.sv
// Shared constants for the LED pattern sequencer: register map, CTRL layout, FSM states.
package led_seq_pkg;

    localparam logic [3:0] ADDR_PAT0  = 4'd0;
    localparam logic [3:0] ADDR_CTRL  = 4'd8;
    localparam logic [3:0] ADDR_DWELL = 4'd9;
    localparam logic [3:0] ADDR_DUTY  = 4'd10;

    localparam int CTRL_ENABLE_BIT   = 0;
    localparam int CTRL_ONE_SHOT_BIT = 1;
    localparam int CTRL_LAST_LSB     = 4;
    localparam int CTRL_LAST_MSB     = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_e;

    function automatic logic [31:0] ctrl_pack(input logic enable, input logic one_shot,
                                              input logic [2:0] last_idx);
        logic [31:0] word;
        word = 32'd0;
        word[CTRL_ENABLE_BIT] = enable;
        word[CTRL_ONE_SHOT_BIT] = one_shot;
        word[CTRL_LAST_MSB:CTRL_LAST_LSB] = last_idx;
        return word;
    endfunction

endpackage

// File: rtl/led_pattern_sequencer_pwm.sv
// PWM dimmer: free-running counter, duty compare and the registered LED output stage.
module led_pwm_gen
    import led_seq_pkg::*;
#(
    parameter int NUM_LEDS = 4,
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PWM_BITS:0]   duty,
    input  logic [NUM_LEDS-1:0] pattern,
    input  logic                out_en,
    output logic [NUM_LEDS-1:0] led_out
);

    logic [PWM_BITS-1:0] pwm_cnt_r;
    logic                pwm_on_s;
    logic [NUM_LEDS-1:0] led_next_s;
    logic [NUM_LEDS-1:0] led_r;

    // Free-running PWM counter, wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pwm_cnt_r <= '0;
        else        pwm_cnt_r <= pwm_cnt_r + PWM_BITS'(1);
    end

    // The extra duty bit lets 2^PWM_BITS mean always on.
    assign pwm_on_s = ({1'b0, pwm_cnt_r} < duty);

    // Next LED value: masked pattern while the sequencer is active.
    always_comb begin
        led_next_s = '0;
        if (out_en) led_next_s = pattern & {NUM_LEDS{pwm_on_s}};
        else        led_next_s = '0;
    end

    // Registered LED drive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) led_r <= '0;
        else        led_r <= led_next_s;
    end

    assign led_out = led_r;

endmodule

// File: rtl/led_pattern_sequencer.sv
// Pattern table + control registers, step FSM with dwell timer, registered read-back.
module led_pattern_sequencer
    import led_seq_pkg::*;
#(
    parameter int NUM_LEDS = 4,
    parameter int DEPTH    = 8,
    parameter int PWM_BITS = 8
) (
    input  logic                ACLK,
    input  logic                ARESETN,
    input  logic                cfg_wr_en,
    input  logic [3:0]          cfg_wr_addr,
    input  logic [31:0]         cfg_wr_data,
    input  logic [3:0]          cfg_rd_addr,
    output logic [31:0]         cfg_rd_data,
    output logic [NUM_LEDS-1:0] led_out,
    output logic [2:0]          seq_idx,
    output logic                seq_busy,
    output logic                wrap_pulse
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [31:0]       pattern_r [DEPTH];
    logic              enable_r, one_shot_r;
    logic [2:0]        last_idx_r;
    logic [31:0]       dwell_r;
    logic [PWM_BITS:0] duty_r;

    seq_state_e  state_r, next_state_s;
    logic [2:0]  seq_idx_r, seq_idx_next_s;
    logic [31:0] dwell_cnt_r, dwell_cnt_next_s;
    logic        wrap_r, wrap_next_s, busy_r;
    logic [31:0] rd_data_r, rd_data_next_s;
    logic        pat_wr_s, ctrl_wr_s, restart_s, step_s, at_last_s;

    assign pat_wr_s  = cfg_wr_en && (cfg_wr_addr < 4'(DEPTH));
    assign ctrl_wr_s = cfg_wr_en && (cfg_wr_addr == ADDR_CTRL);
    assign restart_s = ctrl_wr_s && cfg_wr_data[CTRL_ENABLE_BIT];
    // >= so a DWELL shrunk below the running count steps on the next cycle.
    assign step_s    = (dwell_cnt_r >= dwell_r);
    assign at_last_s = (seq_idx_r >= last_idx_r);

    // Register file write port.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            for (int i = 0; i < DEPTH; i++) pattern_r[i] <= 32'd0;
            enable_r   <= 1'b0;
            one_shot_r <= 1'b0;
            last_idx_r <= 3'd0;
            dwell_r    <= 32'd0;
            duty_r     <= (PWM_BITS+1)'(1) << PWM_BITS;
        end else begin
            if (pat_wr_s) pattern_r[cfg_wr_addr[IDX_W-1:0]] <= cfg_wr_data;
            if (ctrl_wr_s) begin
                enable_r   <= cfg_wr_data[CTRL_ENABLE_BIT];
                one_shot_r <= cfg_wr_data[CTRL_ONE_SHOT_BIT];
                last_idx_r <= cfg_wr_data[CTRL_LAST_MSB:CTRL_LAST_LSB];
            end
            if (cfg_wr_en && (cfg_wr_addr == ADDR_DWELL)) dwell_r <= cfg_wr_data;
            if (cfg_wr_en && (cfg_wr_addr == ADDR_DUTY))  duty_r  <= cfg_wr_data[PWM_BITS:0];
        end
    end

    // FSM state register.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) state_r <= IDLE;
        else          state_r <= next_state_s;
    end

    // FSM next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (enable_r) next_state_s = RUN;
                else          next_state_s = IDLE;
            end
            RUN: begin
                if (!enable_r)                             next_state_s = IDLE;
                else if (step_s && at_last_s && one_shot_r) next_state_s = DONE;
                else                                       next_state_s = RUN;
            end
            DONE: begin
                if (restart_s)      next_state_s = RUN;
                else if (!enable_r) next_state_s = IDLE;
                else                next_state_s = DONE;
            end
            default: next_state_s = IDLE;
        endcase
    end

    // FSM outputs: index, dwell counter and wrap pulse.
    always_comb begin
        seq_idx_next_s   = seq_idx_r;
        dwell_cnt_next_s = dwell_cnt_r;
        wrap_next_s      = 1'b0;
        case (state_r)
            RUN: begin
                if (!enable_r) begin
                    seq_idx_next_s   = 3'd0;
                    dwell_cnt_next_s = 32'd0;
                end else if (step_s) begin
                    dwell_cnt_next_s = 32'd0;
                    if (at_last_s) begin
                        wrap_next_s = 1'b1;
                        if (one_shot_r) seq_idx_next_s = seq_idx_r;
                        else            seq_idx_next_s = 3'd0;
                    end else begin
                        seq_idx_next_s = seq_idx_r + 3'd1;
                    end
                end else begin
                    dwell_cnt_next_s = dwell_cnt_r + 32'd1;
                end
            end
            DONE: begin
                if (restart_s || !enable_r) begin
                    seq_idx_next_s   = 3'd0;
                    dwell_cnt_next_s = 32'd0;
                end else begin
                    seq_idx_next_s   = seq_idx_r;
                    dwell_cnt_next_s = dwell_cnt_r;
                end
            end
            default: begin
                seq_idx_next_s   = 3'd0;
                dwell_cnt_next_s = 32'd0;
            end
        endcase
    end

    // Sequencer datapath registers.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            seq_idx_r   <= 3'd0;
            dwell_cnt_r <= 32'd0;
            wrap_r      <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            seq_idx_r   <= seq_idx_next_s;
            dwell_cnt_r <= dwell_cnt_next_s;
            wrap_r      <= wrap_next_s;
            busy_r      <= (next_state_s == RUN);
        end
    end

    // Read mux; registered below so a same-cycle write is seen on the next read.
    always_comb begin
        rd_data_next_s = 32'd0;
        case (cfg_rd_addr)
            ADDR_CTRL:  rd_data_next_s = ctrl_pack(enable_r, one_shot_r, last_idx_r);
            ADDR_DWELL: rd_data_next_s = dwell_r;
            ADDR_DUTY:  rd_data_next_s = 32'(duty_r);
            default: begin
                if (cfg_rd_addr < 4'(DEPTH)) rd_data_next_s = pattern_r[cfg_rd_addr[IDX_W-1:0]];
                else                         rd_data_next_s = 32'd0;
            end
        endcase
    end

    // Registered read data.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) rd_data_r <= 32'd0;
        else          rd_data_r <= rd_data_next_s;
    end

    led_pwm_gen #(
        .NUM_LEDS (NUM_LEDS),
        .PWM_BITS (PWM_BITS)
    ) u_pwm (
        .clk     (ACLK),
        .rst_n   (ARESETN),
        .duty    (duty_r),
        .pattern (pattern_r[seq_idx_r[IDX_W-1:0]][NUM_LEDS-1:0]),
        .out_en  (state_r != IDLE),
        .led_out (led_out)
    );

    assign cfg_rd_data = rd_data_r;
    assign seq_idx     = seq_idx_r;
    assign seq_busy    = busy_r;
    assign wrap_pulse  = wrap_r;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Directed self-checking bench for led_pattern_sequencer.
module tb_led_pattern_sequencer;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic        cfg_wr_en = 1'b0;
    logic [3:0]  cfg_wr_addr = 4'd0;
    logic [31:0] cfg_wr_data = 32'd0;
    logic [3:0]  cfg_rd_addr = 4'd0;
    logic [31:0] cfg_rd_data;
    logic [3:0]  led_out;
    logic [2:0]  seq_idx;
    logic        seq_busy;
    logic        wrap_pulse;

    int n_checks = 0;
    int n_errors = 0;

    led_pattern_sequencer #(.NUM_LEDS(4), .DEPTH(8), .PWM_BITS(8)) dut (
        .ACLK        (ACLK),
        .ARESETN     (ARESETN),
        .cfg_wr_en   (cfg_wr_en),
        .cfg_wr_addr (cfg_wr_addr),
        .cfg_wr_data (cfg_wr_data),
        .cfg_rd_addr (cfg_rd_addr),
        .cfg_rd_data (cfg_rd_data),
        .led_out     (led_out),
        .seq_idx     (seq_idx),
        .seq_busy    (seq_busy),
        .wrap_pulse  (wrap_pulse)
    );

    always #5 ACLK = ~ACLK;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic reg_write(input logic [3:0] a, input logic [31:0] d);
        cfg_wr_en   = 1'b1;
        cfg_wr_addr = a;
        cfg_wr_data = d;
        tick();
        cfg_wr_en   = 1'b0;
    endtask

    task automatic reg_read(input logic [3:0] a, input logic [31:0] exp, input string tag);
        cfg_rd_addr = a;
        tick();
        check_eq(tag, cfg_rd_data, exp);
    endtask

    initial begin
        int on_cnt;
        int bad_cnt;
        int wraps;

        repeat (3) tick();
        ARESETN = 1'b1;
        tick();
        check_eq("rst_led", 32'(led_out), 32'd0);
        check_eq("rst_idx", 32'(seq_idx), 32'd0);
        check_eq("rst_busy", 32'(seq_busy), 32'd0);
        check_eq("rst_wrap", 32'(wrap_pulse), 32'd0);
        check_eq("rst_rd", cfg_rd_data, 32'd0);
        reg_read(4'd10, 32'd256, "rst_duty");
        reg_read(4'd8, 32'd0, "rst_ctrl");

        // pattern table write then read-back
        for (int i = 0; i < 8; i++) reg_write(4'(i), 32'(i + 1));
        for (int i = 0; i < 8; i++) reg_read(4'(i), 32'(i + 1), "pat_rd");

        // DWELL=3, last_idx=3: four cycles per step, wrap every 16
        reg_write(4'd9, 32'd3);
        reg_write(4'd8, 32'h31);
        tick();
        check_eq("run_busy", 32'(seq_busy), 32'd1);
        for (int t = 0; t <= 20; t++) begin
            check_eq("run_idx", 32'(seq_idx), 32'((t / 4) % 4));
            if (t >= 1) check_eq("run_led", 32'(led_out), 32'(((t - 1) / 4) % 4 + 1));
            check_eq("run_wrap", 32'(wrap_pulse), (t == 16) ? 32'd1 : 32'd0);
            tick();
        end
        reg_write(4'd8, 32'h0);
        tick();
        tick();
        check_eq("dis_led", 32'(led_out), 32'd0);
        check_eq("dis_idx", 32'(seq_idx), 32'd0);

        // clear enable at idx 5, then re-enable
        reg_write(4'd9, 32'd0);
        reg_write(4'd8, 32'h71);
        tick();
        check_eq("clr_idx0", 32'(seq_idx), 32'd0);
        repeat (4) tick();
        check_eq("clr_idx4", 32'(seq_idx), 32'd4);
        reg_write(4'd8, 32'h70);
        check_eq("clr_idx5", 32'(seq_idx), 32'd5);
        tick();
        check_eq("clr_idle_idx", 32'(seq_idx), 32'd0);
        check_eq("clr_idle_busy", 32'(seq_busy), 32'd0);
        check_eq("clr_led_late", 32'(led_out), 32'd6);
        tick();
        check_eq("clr_led_off", 32'(led_out), 32'd0);
        reg_write(4'd8, 32'h71);
        tick();
        check_eq("reen_idx", 32'(seq_idx), 32'd0);
        check_eq("reen_busy", 32'(seq_busy), 32'd1);
        tick();
        check_eq("reen_idx1", 32'(seq_idx), 32'd1);

        // one-shot, last_idx=1, DWELL=0
        reg_write(4'd8, 32'h0);
        tick();
        tick();
        reg_write(4'd8, 32'h13);
        tick();
        check_eq("os_idx0", 32'(seq_idx), 32'd0);
        check_eq("os_busy0", 32'(seq_busy), 32'd1);
        wraps = 0;
        tick();
        check_eq("os_idx1", 32'(seq_idx), 32'd1);
        check_eq("os_led1", 32'(led_out), 32'd1);
        wraps += int'(wrap_pulse);
        tick();
        check_eq("os_done_busy", 32'(seq_busy), 32'd0);
        check_eq("os_done_wrap", 32'(wrap_pulse), 32'd1);
        check_eq("os_done_led", 32'(led_out), 32'd2);
        wraps += int'(wrap_pulse);
        for (int t = 0; t < 6; t++) begin
            tick();
            wraps += int'(wrap_pulse);
            check_eq("os_hold_led", 32'(led_out), 32'd2);
            check_eq("os_hold_idx", 32'(seq_idx), 32'd1);
        end
        check_eq("os_wraps", 32'(wraps), 32'd1);
        reg_write(4'd8, 32'h13);
        check_eq("os_restart_idx", 32'(seq_idx), 32'd0);
        check_eq("os_restart_busy", 32'(seq_busy), 32'd1);

        // PWM duty
        reg_write(4'd8, 32'h0);
        tick();
        tick();
        reg_write(4'd0, 32'hF);
        reg_write(4'd10, 32'd64);
        reg_write(4'd8, 32'h01);
        tick();
        tick();
        on_cnt = 0;
        bad_cnt = 0;
        for (int t = 0; t < 256; t++) begin
            if (led_out == 4'hF) on_cnt++;
            else if (led_out != 4'h0) bad_cnt++;
            tick();
        end
        check_eq("pwm64_on", 32'(on_cnt), 32'd64);
        check_eq("pwm64_bad", 32'(bad_cnt), 32'd0);
        reg_write(4'd10, 32'd0);
        tick();
        tick();
        on_cnt = 0;
        for (int t = 0; t < 256; t++) begin
            if (led_out != 4'h0) on_cnt++;
            tick();
        end
        check_eq("pwm0_on", 32'(on_cnt), 32'd0);
        reg_write(4'd10, 32'd256);
        tick();
        tick();
        on_cnt = 0;
        for (int t = 0; t < 256; t++) begin
            if (led_out == 4'hF) on_cnt++;
            tick();
        end
        check_eq("pwm256_on", 32'(on_cnt), 32'd256);

        // same-address read/write, reserved bits, unmapped
        reg_write(4'd8, 32'h0);
        cfg_rd_addr = 4'd2;
        reg_write(4'd2, 32'hDEADBEEF);
        check_eq("rw_old", cfg_rd_data, 32'd3);
        tick();
        check_eq("rw_new", cfg_rd_data, 32'hDEADBEEF);
        reg_write(4'd8, 32'hFFFFFF7C);
        reg_read(4'd8, 32'h70, "ctrl_rsvd");
        reg_read(4'd11, 32'd0, "unmapped");
        reg_write(4'd9, 32'h12345678);
        reg_read(4'd9, 32'h12345678, "dwell_rd");

        // async reset mid-step
        reg_write(4'd9, 32'd5);
        reg_write(4'd8, 32'h71);
        cfg_rd_addr = 4'd1;
        repeat (3) tick();
        check_eq("pre_rst_led", 32'(led_out), 32'hF);
        check_eq("pre_rst_rd", cfg_rd_data, 32'd2);
        #2;
        ARESETN = 1'b0;
        #1;
        check_eq("arst_led", 32'(led_out), 32'd0);
        check_eq("arst_idx", 32'(seq_idx), 32'd0);
        check_eq("arst_busy", 32'(seq_busy), 32'd0);
        check_eq("arst_wrap", 32'(wrap_pulse), 32'd0);
        check_eq("arst_rd", cfg_rd_data, 32'd0);
        tick();
        tick();
        ARESETN = 1'b1;
        reg_read(4'd8, 32'd0, "post_ctrl");
        reg_read(4'd1, 32'd0, "post_pat1");
        reg_read(4'd9, 32'd0, "post_dwell");
        reg_read(4'd10, 32'd256, "post_duty");
        check_eq("post_busy", 32'(seq_busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/led_pattern_sequencer.md
# led_pattern_sequencer

Downstream consumer of the AXI LED peripheral's register file. It holds an 8-entry pattern table and control/dwell/duty registers, all written through a simple register write port driven by the AXI slave's write-commit logic. It steps through the table at a programmable rate and drives PWM-dimmed LED outputs. Read-back goes through a registered read port, so an AXI burst write of words 1..8 followed by a burst read returns identical data.

## Interface
- NUM_LEDS, 4, LED outputs driven; pattern bits [NUM_LEDS-1:0] are used.
- DEPTH, 8, pattern table entries; must be a power of 2, at most 8.
- PWM_BITS, 8, width of the PWM counter.
- ACLK  in  1  sole clock.
- ARESETN  in  1  reset, asynchronous and active-low.
- cfg_wr_en  in  1  one-cycle write strobe.
- cfg_wr_addr  in  4  word index:
  - 0–7 pattern[i];
  - 8 CTRL: bit0 enable, bit1 one_shot, bits[6:4] last_idx;
  - 9 DWELL, 32 b;
  - 10 DUTY, PWM_BITS+1 b.
- cfg_wr_data  in  32  write data.
- cfg_rd_addr  in  4  read word index, same map as writes.
- cfg_rd_data  out  32  registered read data; unmapped addresses read 0.
- led_out  out  NUM_LEDS  LED drive.
- seq_idx  out  3  current table index.
- seq_busy  out  1  high in RUN.
- wrap_pulse  out  1  one-cycle pulse on the step from last_idx to 0, or on one-shot completion.

## Operation
- **Reset values:**
  - pattern[*] = 0, CTRL = 0, DWELL = 0, DUTY = 2^PWM_BITS (full on).
  - FSM in IDLE; seq_idx = 0.
  - led_out, cfg_rd_data, seq_busy, wrap_pulse all 0.
- **IDLE:**
  - led_out = 0; dwell counter and seq_idx held at 0.
  - CTRL.enable = 1 → RUN on the next edge.
- **RUN:**
  - The dwell counter counts 0..DWELL. At DWELL the sequencer steps and the counter clears. DWELL = 0 means one cycle per step.
  - Step rule when seq_idx ≥ last_idx:
    - if one_shot = 1: go to DONE and pulse wrap_pulse;
    - otherwise: seq_idx ← 0 and pulse wrap_pulse.
  - Step rule otherwise: seq_idx increments.
- **DONE:**
  - led_out holds the last pattern, with PWM still applied; seq_busy = 0.
  - Writing CTRL with enable = 1 restarts the sequence at idx 0 in RUN.
- **enable ← 0 from any state:** IDLE next cycle; seq_idx = 0; led_out = 0 on the following cycle.
- **PWM:**
  - pwm_cnt is a free-running PWM_BITS counter that wraps naturally.
  - led_out = pattern[seq_idx][NUM_LEDS-1:0] AND replicate(pwm_cnt < DUTY).
  - DUTY = 0 gives always off; DUTY ≥ 2^PWM_BITS gives always on.
- **Writes to live registers:**
  - Writing the currently displayed pattern entry takes effect on led_out two edges after the strobe (register write, then output register).
  - Writing last_idx below the current seq_idx takes effect at the next step boundary, which wraps to 0.
  - Writing DWELL mid-step compares against the new value immediately. If the counter already exceeds the new DWELL, the step fires on the next cycle.
- **Simultaneous read and write to the same address:** cfg_rd_data returns the old value; the new value is visible on the next read.
- **Width rules:**
  - DWELL is unsigned 32 b.
  - Unused high bits of pattern words are stored and read back unchanged; all 32 b are kept.
  - Reserved CTRL bits read 0.

## Timing
- led_out is registered: one cycle of latency from seq_idx or pwm_cnt change.
- cfg_rd_data is valid one cycle after cfg_rd_addr is sampled.
- Step period is DWELL + 1 cycles.
- wrap_pulse is asserted in the same cycle that seq_idx shows 0, or the cycle DONE is entered.
- Async reset clears all state immediately, including mid-step; release is synchronised by the system reset bridge.

## Structure
- Package led_seq_pkg holds:
  - address constants: ADDR_PAT0, ADDR_CTRL = 8, ADDR_DWELL = 9, ADDR_DUTY = 10;
  - the CTRL bit positions;
  - the FSM state enum: IDLE, RUN, DONE.
- One sub-module: led_pwm_gen (pwm_cnt plus compare, output enable). The register file and FSM stay in the top level.

## Test plan
- Write pattern[0..7] = 1..8, then read all eight → cfg_rd_data returns 1..8 in order, each one cycle after its address.
- DWELL = 3, last_idx = 3, DUTY = 256, enable → seq_idx sequence 0,1,2,3,0 with 4 cycles per step; led_out tracks 1,2,3,4 one cycle late; wrap_pulse fires once per 16 cycles.
- one_shot = 1, last_idx = 1, DWELL = 0 → seq_idx 0,1, then DONE; seq_busy falls; led_out holds 2; exactly one wrap_pulse.
- DUTY = 64, pattern[0] = 0xF → each LED is high for 64 of every 256 cycles; DUTY = 0 → always 0.
- Clear enable mid-RUN at idx 5 → IDLE, seq_idx = 0, led_out = 0 the next cycle. Re-enable → restart at idx 0.
- Assert ARESETN low mid-step → all outputs 0 immediately; after release, CTRL and pattern read 0.
